// File: rtl/pc_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_ctrl_if
// Brief    : Instruction-memory handshake and PC-datapath control bundle
//            between the sequencer and its surroundings.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_seq_ctrl_if #(
    parameter int ADDSIZE = 4,
    parameter int JMPSIZE = 8
);
    localparam int c_instr_w = 4 + ADDSIZE + JMPSIZE;

    logic                 imem_req;
    logic                 imem_ack;
    logic [c_instr_w-1:0] instr;
    logic                 zero_flag;
    logic                 jmp;
    logic                 branch;
    logic                 wren;
    logic [ADDSIZE-1:0]   ra;
    logic [ADDSIZE-1:0]   rw;
    logic [JMPSIZE-1:0]   disp;
    logic                 clken;

    modport master (
        output imem_req, jmp, branch, wren, ra, rw, disp, clken,
        input  imem_ack, instr, zero_flag
    );

    modport slave (
        input  imem_req, jmp, branch, wren, ra, rw, disp, clken,
        output imem_ack, instr, zero_flag
    );
endinterface
`default_nettype wire

// File: rtl/pc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_ctrl
// Brief    : Fetch/decode/execute sequencer driving the PC datapath controls,
//            one clken pulse per retired instruction.
// Revision : 1.0 - initial release
// ============================================================================
module pc_seq_ctrl #(
    parameter int WIDTH   = 16,
    parameter int ADDSIZE = 4,
    parameter int JMPSIZE = 8,
    parameter int CNTW    = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            run,
    pc_seq_ctrl_if.master        bus,
    output logic                 halted,
    output logic                 illegal,
    output logic [CNTW-1:0]      retired
);

    localparam int c_instr_w = 4 + ADDSIZE + JMPSIZE;

    localparam logic [3:0] c_op_nop  = 4'h0;
    localparam logic [3:0] c_op_br   = 4'h1;
    localparam logic [3:0] c_op_bz   = 4'h2;
    localparam logic [3:0] c_op_bnz  = 4'h3;
    localparam logic [3:0] c_op_jr   = 4'h4;
    localparam logic [3:0] c_op_jal  = 4'h5;
    localparam logic [3:0] c_op_halt = 4'hF;

    localparam logic [CNTW-1:0] c_cnt_one = {{(CNTW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    // The datapath sign-extends disp, so it must be at least as wide.
    if (WIDTH < JMPSIZE) begin : g_width_below_disp
    end

    state_t                r_state;
    logic [c_instr_w-1:0]  r_ir;
    logic                  r_is_halt;

    logic [3:0]            w_opcode;
    logic [ADDSIZE-1:0]    w_rega;
    logic [JMPSIZE-1:0]    w_disp;

    assign w_opcode = r_ir[c_instr_w-1 -: 4];
    assign w_rega   = r_ir[c_instr_w-5 -: ADDSIZE];
    assign w_disp   = r_ir[JMPSIZE-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ir         <= '0;
            r_is_halt    <= 1'b0;
            bus.imem_req <= 1'b0;
            bus.jmp      <= 1'b0;
            bus.branch   <= 1'b0;
            bus.wren     <= 1'b0;
            bus.ra       <= '0;
            bus.rw       <= '0;
            bus.disp     <= '0;
            bus.clken    <= 1'b0;
            halted       <= 1'b0;
            illegal      <= 1'b0;
            retired      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state      <= S_FETCH;
                        bus.imem_req <= 1'b1;
                    end
                end

                S_FETCH: begin
                    if (bus.imem_ack) begin
                        r_ir         <= bus.instr;
                        bus.imem_req <= 1'b0;
                        r_state      <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    // Controls are registered here so they are valid for the whole EXEC cycle.
                    r_state    <= S_EXEC;
                    bus.clken  <= 1'b1;
                    retired    <= retired + c_cnt_one;
                    bus.jmp    <= 1'b0;
                    bus.branch <= 1'b0;
                    bus.wren   <= 1'b0;
                    bus.ra     <= w_rega;
                    bus.rw     <= w_disp[ADDSIZE-1:0];
                    bus.disp   <= w_disp;
                    r_is_halt  <= 1'b0;
                    case (w_opcode)
                        c_op_nop:  ;
                        c_op_br:   bus.branch <= 1'b1;
                        c_op_bz:   bus.branch <= bus.zero_flag;
                        c_op_bnz:  bus.branch <= ~bus.zero_flag;
                        c_op_jr:   bus.jmp    <= 1'b1;
                        c_op_jal: begin
                            bus.jmp  <= 1'b1;
                            bus.wren <= 1'b1;
                        end
                        c_op_halt: begin
                            bus.ra    <= '0;
                            bus.rw    <= '0;
                            bus.disp  <= '0;
                            r_is_halt <= 1'b1;
                        end
                        default:   illegal <= 1'b1;
                    endcase
                end

                S_EXEC: begin
                    bus.clken  <= 1'b0;
                    bus.jmp    <= 1'b0;
                    bus.branch <= 1'b0;
                    bus.wren   <= 1'b0;
                    if (r_is_halt) begin
                        r_state <= S_HALT;
                        halted  <= 1'b1;
                    end else if (run) begin
                        r_state      <= S_FETCH;
                        bus.imem_req <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_HALT: r_state <= S_HALT;

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_seq_ctrl
// Brief    : Directed bench with a transaction-level scoreboard for pc_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_seq_ctrl;

    localparam int ADDSIZE = 4;
    localparam int JMPSIZE = 8;
    localparam int CNTW    = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            run = 1'b0;
    logic            halted;
    logic            illegal;
    logic [CNTW-1:0] retired;

    pc_seq_ctrl_if #(.ADDSIZE(ADDSIZE), .JMPSIZE(JMPSIZE)) bus ();

    pc_seq_ctrl #(
        .WIDTH  (16),
        .ADDSIZE(ADDSIZE),
        .JMPSIZE(JMPSIZE),
        .CNTW   (CNTW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .bus    (bus.master),
        .halted (halted),
        .illegal(illegal),
        .retired(retired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         due;
        logic       jmp;
        logic       branch;
        logic       wren;
        logic [3:0] ra;
        logic [3:0] rw;
        logic [7:0] disp;
        logic       ill;
        logic       hlt;
    } exec_t;

    exec_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural meaning of one instruction as seen in its EXEC cycle.
    function automatic exec_t model(input logic [15:0] w, input logic zf, input int due);
        exec_t e;
        e.due = due;
        e.jmp = 1'b0; e.branch = 1'b0; e.wren = 1'b0; e.ill = 1'b0; e.hlt = 1'b0;
        e.ra = w[11:8]; e.disp = w[7:0]; e.rw = w[3:0];
        case (w[15:12])
            4'h0: ;
            4'h1: e.branch = 1'b1;
            4'h2: e.branch = zf;
            4'h3: e.branch = !zf;
            4'h4: e.jmp = 1'b1;
            4'h5: begin e.jmp = 1'b1; e.wren = 1'b1; end
            4'hF: begin e.hlt = 1'b1; e.ra = 4'h0; e.rw = 4'h0; e.disp = 8'h00; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    logic [3:0] m_ra, m_rw;
    logic [7:0] m_disp;
    logic [3:0] m_ret;
    logic       m_ill, m_hlt, m_hlt_next;
    logic       x_ck, x_jmp, x_br, x_wr;
    exec_t      cur;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_ra = '0; m_rw = '0; m_disp = '0; m_ret = '0;
            m_ill = 1'b0; m_hlt = 1'b0; m_hlt_next = 1'b0;
        end else begin
            if (m_hlt_next) begin
                m_hlt      = 1'b1;
                m_hlt_next = 1'b0;
            end
            x_ck = 1'b0; x_jmp = 1'b0; x_br = 1'b0; x_wr = 1'b0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                cur   = sb.pop_front();
                x_ck  = 1'b1;
                x_jmp = cur.jmp; x_br = cur.branch; x_wr = cur.wren;
                m_ra  = cur.ra; m_rw = cur.rw; m_disp = cur.disp;
                m_ret = m_ret + 4'd1;
                if (cur.ill) m_ill = 1'b1;
                if (cur.hlt) m_hlt_next = 1'b1;
            end
            check("ctrl", {12'h0, bus.clken, bus.jmp, bus.branch, bus.wren, bus.ra, bus.rw, bus.disp},
                          {12'h0, x_ck, x_jmp, x_br, x_wr, m_ra, m_rw, m_disp});
            check("status", {26'h0, halted, illegal, retired}, {26'h0, m_hlt, m_ill, m_ret});
        end
    end

    // Entered and left at #1 after a rising edge; returns in the DECODE cycle.
    task automatic fetch(input logic [15:0] w, input logic zf, input int waits,
                         input bit drop_run, output int req_cycles);
        int n = 0;
        req_cycles = 0;
        while (bus.imem_req !== 1'b1) begin
            if (n >= 40) begin
                n_checks++; n_fail++;
                $display("FAIL fetch_timeout: actual=imem_req low required=imem_req high (cycle %0d)", cyc);
                return;
            end
            @(posedge clk); #1;
            n++;
        end
        if (drop_run) run = 1'b0;
        for (int i = 0; i < waits; i++) begin
            if (bus.imem_req === 1'b1) req_cycles++;
            @(posedge clk); #1;
        end
        bus.instr     = w;
        bus.zero_flag = zf;
        bus.imem_ack  = 1'b1;
        if (bus.imem_req === 1'b1) req_cycles++;
        sb.push_back(model(w, zf, cyc + 2));
        @(posedge clk); #1;
        bus.imem_ack = 1'b0;
        bus.instr    = 16'hA5A5;
    endtask

    task automatic exec_lit(input string name, input logic [19:0] exp);
        @(posedge clk); #1;
        check(name, {12'h0, bus.clken, bus.jmp, bus.branch, bus.wren, bus.ra, bus.rw, bus.disp},
                    {12'h0, exp});
    endtask

    task automatic count_req(input string name, input int ncyc);
        int hits = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            if (bus.imem_req !== 1'b0 || bus.clken !== 1'b0) hits++;
        end
        check(name, hits, 0);
    endtask

    initial begin
        int rc;
        bus.imem_ack  = 1'b0;
        bus.instr     = '0;
        bus.zero_flag = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {bus.imem_req, bus.clken, bus.jmp, bus.branch, bus.wren,
                              bus.ra, bus.rw, bus.disp, halted, illegal, retired}, 32'h0);
        rst = 1'b0;
        run = 1'b1;

        for (int i = 0; i < 4; i++) fetch(16'h0000, 1'b0, 0, 1'b0, rc);
        exec_lit("nop4_exec", {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00});
        check("nop4_retired", {28'h0, retired}, 32'd4);

        for (int i = 0; i < 12; i++) fetch(16'h0000, 1'b0, 0, 1'b0, rc);
        @(posedge clk); #1;
        check("retired_wrap", {28'h0, retired}, 32'd0);

        fetch(16'h2005, 1'b1, 0, 1'b0, rc);
        exec_lit("bz_taken", {1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h5, 8'h05});
        fetch(16'h2005, 1'b0, 0, 1'b0, rc);
        exec_lit("bz_not_taken", {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h5, 8'h05});
        fetch(16'h30FE, 1'b0, 0, 1'b0, rc);
        exec_lit("bnz_taken", {1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'hE, 8'hFE});
        fetch(16'h5307, 1'b0, 0, 1'b0, rc);
        exec_lit("jal_exec", {1'b1, 1'b1, 1'b0, 1'b1, 4'h3, 4'h7, 8'h07});
        exec_lit("jal_after", {1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 4'h7, 8'h07});

        // Reset while the next fetch is outstanding.
        for (int i = 0; i < 10 && bus.imem_req !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        check("req_before_reset", {31'h0, bus.imem_req}, 32'h1);
        rst = 1'b1;
        #1;
        check("reset_midfetch", {bus.imem_req, bus.clken, bus.jmp, bus.branch, bus.wren,
                                 bus.ra, bus.rw, bus.disp, halted, illegal, retired}, 32'h0);
        run = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        count_req("idle_no_req", 10);

        run = 1'b1;
        fetch(16'h1234, 1'b0, 5, 1'b1, rc);
        check("wait_req_cycles", rc, 6);
        exec_lit("br_after_wait", {1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 4'h4, 8'h34});
        count_req("idle_after_drop", 6);

        run = 1'b1;
        fetch(16'h7000, 1'b0, 0, 1'b0, rc);
        exec_lit("illegal_as_nop", {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00});
        check("illegal_flag", {31'h0, illegal}, 32'h1);
        fetch(16'hF000, 1'b0, 0, 1'b0, rc);
        exec_lit("halt_exec", {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00});
        @(posedge clk); #1;
        check("halted_flags", {29'h0, halted, illegal, bus.imem_req}, 32'h6);
        count_req("halt_absorbing", 20);
        check("retired_at_halt", {28'h0, retired}, 32'd3);

        rst = 1'b1;
        #1;
        check("reset_clears", {26'h0, halted, illegal, retired}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        run = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
